// File: rtl/sdram_arbiter.sv
// rtl/sdram_arbiter.sv - two-port burst arbiter in front of an SDRAM controller
//
// Purpose:
//   Shares one SDRAM controller between a write requester (port 0, RX
//   capture) and a read requester (port 1, TX playback). Each grant moves
//   BURST_LEN consecutive words starting at the latched start address
//   (modulo 2^ADDR_WIDTH). The arbiter returns to IDLE for one cycle after
//   every burst and re-arbitrates there.
//
// Configuration macro:
//   SDRAM_ARB_RX_PRIO_EN  defined   : port 0 always wins simultaneous requests
//                         undefined : simultaneous requests go round-robin
//
// Ports:
//   clk, reset            single clock; asynchronous active-high reset
//   p0_req/p0_addr        port 0 burst request and start address
//   p0_wdata              port 0 current write word (passed straight through)
//   p0_gnt/p0_ack         port 0 owns the burst / current word accepted
//   p1_req/p1_addr        port 1 burst request and start address
//   p1_gnt                port 1 owns the burst
//   p1_rdata/p1_rvalid    registered copy of controller read data/strobe
//   az_*                  command side of the SDRAM controller
//   za_*                  response side of the SDRAM controller
//   rd_pending            reads issued but not yet returned (saturating)

module sdram_arbiter #(
  parameter int ADDR_WIDTH = 22,
  parameter int DATA_WIDTH = 16,
  parameter int BURST_LEN  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  p0_req,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  input  logic [DATA_WIDTH-1:0] p0_wdata,
  output logic                  p0_gnt,
  output logic                  p0_ack,
  input  logic                  p1_req,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  output logic                  p1_gnt,
  output logic [DATA_WIDTH-1:0] p1_rdata,
  output logic                  p1_rvalid,
  output logic [ADDR_WIDTH-1:0] az_addr,
  output logic [DATA_WIDTH-1:0] az_data,
  output logic [1:0]            az_be_n,
  output logic                  az_cs,
  output logic                  az_rd_n,
  output logic                  az_wr_n,
  input  logic [DATA_WIDTH-1:0] za_data,
  input  logic                  za_valid,
  input  logic                  za_waitrequest,
  output logic [7:0]            rd_pending
);

  localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR_BURST = 2'd1,
    RD_BURST = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   start_q, start_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    last_p1_q, last_p1_d;   // 1: port 1 was served last
  logic [7:0]              pend_q, pend_d;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic                    rvalid_q;

  logic                    pick_p0;
  logic [ADDR_WIDTH-1:0]   word_addr;
  logic                    rd_issue;

  // Arbitration only matters in IDLE; pick_p0 selects port 0 when it is
  // requesting and either alone or entitled to win the contention.
`ifdef SDRAM_ARB_RX_PRIO_EN
  assign pick_p0 = p0_req;
`else
  assign pick_p0 = p0_req && (!p1_req || last_p1_q);
`endif

  // Natural truncation to ADDR_WIDTH gives the wrap past the top address.
  assign word_addr = start_q + ADDR_WIDTH'(cnt_q);

  assign rd_issue = (state_q == RD_BURST) && !za_waitrequest;

  // Next-state and command outputs. Command outputs are pure functions of
  // the registered state/count, so a waitrequest stall holds them stable.
  always_comb begin
    state_d   = state_q;
    start_d   = start_q;
    cnt_d     = cnt_q;
    last_p1_d = last_p1_q;
    p0_gnt    = 1'b0;
    p1_gnt    = 1'b0;
    p0_ack    = 1'b0;
    az_cs     = 1'b0;
    az_rd_n   = 1'b1;
    az_wr_n   = 1'b1;
    az_be_n   = 2'b00;
    az_addr   = '0;
    az_data   = '0;

    case (state_q)
      IDLE: begin
        if (p0_req || p1_req) begin
          cnt_d = '0;
          if (pick_p0) begin
            state_d   = WR_BURST;
            start_d   = p0_addr;
            last_p1_d = 1'b0;
          end else begin
            state_d   = RD_BURST;
            start_d   = p1_addr;
            last_p1_d = 1'b1;
          end
        end
      end

      WR_BURST: begin
        p0_gnt  = 1'b1;
        az_cs   = 1'b1;
        az_wr_n = 1'b0;
        az_addr = word_addr;
        az_data = p0_wdata;
        p0_ack  = !za_waitrequest;
        if (!za_waitrequest) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_d = IDLE;
          end
        end
      end

      RD_BURST: begin
        p1_gnt  = 1'b1;
        az_cs   = 1'b1;
        az_rd_n = 1'b0;
        az_addr = word_addr;
        if (!za_waitrequest) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outstanding-read counter: a same-cycle issue and return cancel out;
  // saturates at 255 and never goes below zero.
  always_comb begin
    pend_d = pend_q;
    if (rd_issue && !za_valid) begin
      if (pend_q != 8'hFF) begin
        pend_d = pend_q + 8'd1;
      end
    end else if (!rd_issue && za_valid) begin
      if (pend_q != 8'h00) begin
        pend_d = pend_q - 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      start_q   <= '0;
      cnt_q     <= '0;
      last_p1_q <= 1'b1;
      pend_q    <= 8'd0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      start_q   <= start_d;
      cnt_q     <= cnt_d;
      last_p1_q <= last_p1_d;
      pend_q    <= pend_d;
      rdata_q   <= za_data;
      rvalid_q  <= za_valid;
    end
  end

  assign p1_rdata   = rdata_q;
  assign p1_rvalid  = rvalid_q;
  assign rd_pending = pend_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb/tb_sdram_arbiter.sv - self-checking bench for sdram_arbiter
module tb_sdram_arbiter;

  localparam int AW    = 22;
  localparam int DW    = 16;
  localparam int BL    = 8;
  localparam int AMASK = (1 << AW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          p0_req = 1'b0;
  logic [AW-1:0] p0_addr = '0;
  logic [DW-1:0] p0_wdata = '0;
  logic          p0_gnt, p0_ack;
  logic          p1_req = 1'b0;
  logic [AW-1:0] p1_addr = '0;
  logic          p1_gnt;
  logic [DW-1:0] p1_rdata;
  logic          p1_rvalid;
  logic [AW-1:0] az_addr;
  logic [DW-1:0] az_data;
  logic [1:0]    az_be_n;
  logic          az_cs, az_rd_n, az_wr_n;
  logic [DW-1:0] za_data = '0;
  logic          za_valid = 1'b0;
  logic          za_waitrequest = 1'b0;
  logic [7:0]    rd_pending;

  always #5 clk = ~clk;

  sdram_arbiter #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .BURST_LEN (BL)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .p0_req        (p0_req),
    .p0_addr       (p0_addr),
    .p0_wdata      (p0_wdata),
    .p0_gnt        (p0_gnt),
    .p0_ack        (p0_ack),
    .p1_req        (p1_req),
    .p1_addr       (p1_addr),
    .p1_gnt        (p1_gnt),
    .p1_rdata      (p1_rdata),
    .p1_rvalid     (p1_rvalid),
    .az_addr       (az_addr),
    .az_data       (az_data),
    .az_be_n       (az_be_n),
    .az_cs         (az_cs),
    .az_rd_n       (az_rd_n),
    .az_wr_n       (az_wr_n),
    .za_data       (za_data),
    .za_valid      (za_valid),
    .za_waitrequest(za_waitrequest),
    .rd_pending    (rd_pending)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, want, $time);
    end
  endtask

  // Transaction-level model: owner of the current burst, the addresses the
  // burst still has to present, who was served last, and outstanding reads.
  int            m_owner = 0;      // 0 none, 1 port 0, 2 port 1
  int            m_addrs[$];
  int            m_last = 2;
  int            m_pend = 0;
  int            m_win;
  logic          m_rvalid = 1'b0;
  logic [DW-1:0] m_rdata = '0;

  // Observations of the DUT used by the literal checks.
  int   wr_log[$];
  int   rd_log[$];
  int   gnt_log[$];
  int   ack_cnt = 0;
  int   p0_gnt_cycles = 0;
  int   pend_peak = 0;
  logic prev_p0_gnt = 1'b0;
  logic prev_p1_gnt = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      chk("rst_p0_gnt", p0_gnt, 0);
      chk("rst_p1_gnt", p1_gnt, 0);
      chk("rst_p0_ack", p0_ack, 0);
      chk("rst_p1_rvalid", p1_rvalid, 0);
      chk("rst_p1_rdata", p1_rdata, 0);
      chk("rst_az_cs", az_cs, 0);
      chk("rst_az_rd_n", az_rd_n, 1);
      chk("rst_az_wr_n", az_wr_n, 1);
      chk("rst_az_addr", az_addr, 0);
      chk("rst_az_data", az_data, 0);
      chk("rst_rd_pending", rd_pending, 0);
      m_owner = 0;
      m_addrs.delete();
      m_last = 2;
      m_pend = 0;
      m_rvalid = 1'b0;
      m_rdata = '0;
      prev_p0_gnt = 1'b0;
      prev_p1_gnt = 1'b0;
    end else begin
      chk("p0_gnt", p0_gnt, m_owner == 1);
      chk("p1_gnt", p1_gnt, m_owner == 2);
      chk("gnt_exclusive", p0_gnt & p1_gnt, 0);
      chk("az_be_n", az_be_n, 0);
      chk("az_cs", az_cs, m_owner != 0);
      chk("az_wr_n", az_wr_n, m_owner != 1);
      chk("az_rd_n", az_rd_n, m_owner != 2);
      chk("az_addr", az_addr, (m_owner != 0) ? m_addrs[0] : 0);
      chk("az_data", az_data, (m_owner == 1) ? int'(p0_wdata) : 0);
      chk("p0_ack", p0_ack, (m_owner == 1) && !za_waitrequest);
      chk("p1_rvalid", p1_rvalid, m_rvalid);
      chk("p1_rdata", p1_rdata, m_rdata);
      chk("rd_pending", rd_pending, m_pend);

      if (p0_gnt && !prev_p0_gnt) gnt_log.push_back(0);
      if (p1_gnt && !prev_p1_gnt) gnt_log.push_back(1);
      prev_p0_gnt = p0_gnt;
      prev_p1_gnt = p1_gnt;
      if (p0_gnt) p0_gnt_cycles++;
      if (p0_ack) ack_cnt++;
      if (az_cs && !az_wr_n && !za_waitrequest) wr_log.push_back(int'(az_addr));
      if (az_cs && !az_rd_n && !za_waitrequest) rd_log.push_back(int'(az_addr));
      if (int'(rd_pending) > pend_peak) pend_peak = int'(rd_pending);

      // Predict what the coming clock edge does.
      m_rvalid = za_valid;
      m_rdata  = za_data;
      m_pend   = m_pend + ((m_owner == 2 && !za_waitrequest) ? 1 : 0) - (za_valid ? 1 : 0);
      if (m_pend > 255) m_pend = 255;
      if (m_pend < 0) m_pend = 0;
      if (m_owner != 0) begin
        if (!za_waitrequest) begin
          void'(m_addrs.pop_front());
          if (m_addrs.size() == 0) m_owner = 0;
        end
      end else if (p0_req || p1_req) begin
`ifdef SDRAM_ARB_RX_PRIO_EN
        m_win = p0_req ? 1 : 2;
`else
        if (p0_req && p1_req) m_win = (m_last == 2) ? 1 : 2;
        else m_win = p0_req ? 1 : 2;
`endif
        m_owner = m_win;
        m_last  = m_win;
        for (int i = 0; i < BL; i++) begin
          m_addrs.push_back((int'(m_win == 1 ? p0_addr : p1_addr) + i) & AMASK);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_logs();
    wr_log.delete();
    rd_log.delete();
    gnt_log.delete();
    ack_cnt = 0;
    p0_gnt_cycles = 0;
    pend_peak = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    int exp_rd[8];

    #2;
    chk("init_az_rd_n", az_rd_n, 1);
    chk("init_p1_gnt", p1_gnt, 0);
    tick(2);
    reset = 1'b0;
    tick(2);

    // Single write burst at 0x10, requester drops req after the grant.
    clear_logs();
    p0_addr = 22'h000010;
    p0_req  = 1'b1;
    tick(1);
    p0_req = 1'b0;
    for (int i = 0; i < 12; i++) begin
      p0_wdata = 16'hA000 + 16'(i);
      tick(1);
    end
    chk("t1_wr_count", wr_log.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < wr_log.size()) chk("t1_wr_addr", wr_log[i], 32'h10 + i);
    end
    chk("t1_ack_pulses", ack_cnt, 8);
    chk("t1_gnt_cycles", p0_gnt_cycles, 8);

    // Read burst wrapping past the top address with a 3-cycle stall on word 2.
    clear_logs();
    exp_rd = '{32'h3FFFFC, 32'h3FFFFD, 32'h3FFFFE, 32'h3FFFFF, 0, 1, 2, 3};
    p1_addr = 22'h3FFFFC;
    p1_req  = 1'b1;
    tick(1);
    p1_req = 1'b0;
    for (int i = 0; i < 12; i++) begin
      za_waitrequest = (i >= 1 && i <= 3);
      tick(1);
    end
    za_waitrequest = 1'b0;
    chk("t2_rd_count", rd_log.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < rd_log.size()) chk("t2_rd_addr", rd_log[i], exp_rd[i]);
    end
    chk("t2_pending_peak", pend_peak, 8);
    for (int i = 0; i < 8; i++) begin
      za_valid = 1'b1;
      za_data  = 16'h5000 + 16'(i);
      tick(1);
    end
    za_valid = 1'b0;
    tick(1);
    chk("t2_pending_drained", rd_pending, 0);
    za_valid = 1'b1;
    tick(1);
    za_valid = 1'b0;
    tick(1);
    chk("t2_pending_no_underflow", rd_pending, 0);

    // Return coincident with an issue at rd_pending=3.
    p1_addr = 22'h001000;
    p1_req  = 1'b1;
    tick(1);
    p1_req = 1'b0;
    tick(3);
    chk("t5_pending_before", rd_pending, 3);
    za_valid = 1'b1;
    za_data  = 16'hBEEF;
    tick(1);
    chk("t5_pending_held", rd_pending, 3);
    chk("t5_rvalid", p1_rvalid, 1);
    chk("t5_rdata", p1_rdata, 16'hBEEF);
    za_valid = 1'b0;
    tick(1);
    chk("t5_rvalid_drop", p1_rvalid, 0);
    chk("t5_pending_next", rd_pending, 4);
    tick(6);
    chk("t5_pending_after_burst", rd_pending, 7);
    for (int i = 0; i < 7; i++) begin
      za_valid = 1'b1;
      za_data  = 16'h6000 + 16'(i);
      tick(1);
    end
    za_valid = 1'b0;
    tick(1);
    chk("t5_pending_drained", rd_pending, 0);

    // Both requesters held high continuously.
    clear_logs();
    p0_addr = 22'h000020;
    p1_addr = 22'h000040;
    p0_req  = 1'b1;
    p1_req  = 1'b1;
    tick(40);
    p0_req = 1'b0;
    p1_req = 1'b0;
    tick(12);
    chk("t3_grant_count_ge4", gnt_log.size() >= 4, 1);
    for (int i = 0; i < 4; i++) begin
`ifdef SDRAM_ARB_RX_PRIO_EN
      if (i < gnt_log.size()) chk("t3_grant_order", gnt_log[i], 0);
`else
      if (i < gnt_log.size()) chk("t3_grant_order", gnt_log[i], i % 2);
`endif
    end

    // Reset pulsed on the 4th word of a write burst.
    p0_addr = 22'h000100;
    p0_req  = 1'b1;
    tick(4);
    chk("t4_fourth_word_addr", az_addr, 22'h000103);
    #1;
    reset = 1'b1;
    #1;
    chk("t4_rst_az_cs", az_cs, 0);
    chk("t4_rst_p0_gnt", p0_gnt, 0);
    chk("t4_rst_az_addr", az_addr, 0);
    p0_addr = 22'h000200;
    tick(1);
    clear_logs();
    reset = 1'b0;
    tick(1);
    chk("t4_new_gnt", p0_gnt, 1);
    chk("t4_new_addr", az_addr, 22'h000200);
    p0_req = 1'b0;
    tick(10);
    chk("t4_wr_count", wr_log.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < wr_log.size()) chk("t4_wr_addr", wr_log[i], 32'h200 + i);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 22, SDRAM word-address width (bank, row, column).
REQ-002 SHALL have parameter DATA_WIDTH, default 16, SDRAM word width.
REQ-003 SHALL have parameter BURST_LEN, default 8, words moved per grant (power of two, 2..256).
REQ-004 SHALL have port clk  in  1  single clock for all logic, shared with the SDRAM controller.
REQ-005 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have ports p0_req in 1, p0_addr in ADDR_WIDTH, p0_wdata in DATA_WIDTH: write requester (RX capture path), burst request, start address, current write word.
REQ-007 SHALL have ports p0_gnt out 1, p0_ack out 1: burst owned by port 0; current write word accepted.
REQ-008 SHALL have ports p1_req in 1, p1_addr in ADDR_WIDTH: read requester (TX playback path), burst request and start address.
REQ-009 SHALL have ports p1_gnt out 1, p1_rdata out DATA_WIDTH, p1_rvalid out 1: burst owned by port 1; returned read word and its strobe.
REQ-010 SHALL have ports az_addr out ADDR_WIDTH, az_data out DATA_WIDTH, az_be_n out 2, az_cs out 1, az_rd_n out 1, az_wr_n out 1: command side of the SDRAM controller.
REQ-011 SHALL have ports za_data in DATA_WIDTH, za_valid in 1, za_waitrequest in 1: response side of the SDRAM controller.
REQ-012 SHALL have port rd_pending out 8: reads issued to the controller but not yet returned.

Function
REQ-013 SHALL implement states IDLE, WR_BURST and RD_BURST.
REQ-014 IDLE: SHALL drive az_cs=0, az_rd_n=1, az_wr_n=1, az_be_n=2'b00; with exactly one request pending, SHALL enter that port's burst state on the next edge.
REQ-015 Simultaneous p0_req and p1_req in IDLE: SHALL select per REQ-030/REQ-031.
REQ-016 On entering a burst: SHALL latch the start address, clear word counter, assert the port's gnt in the same cycle as the state change.
REQ-017 WR_BURST: SHALL drive az_cs=1, az_wr_n=0, az_addr=start+count, az_data=p0_wdata (combinational pass-through).
REQ-018 WR_BURST: p0_ack SHALL be 1 in any cycle with za_waitrequest=0; count increments on that cycle.
REQ-019 RD_BURST: SHALL drive az_cs=1, az_rd_n=0, az_addr=start+count; each cycle with za_waitrequest=0 increments count and rd_pending.
REQ-020 za_waitrequest=1 SHALL hold az_addr, az_data, az_cs, az_rd_n, az_wr_n stable and freeze count.
REQ-021 Address arithmetic SHALL be modulo 2^ADDR_WIDTH; a burst crossing the top address SHALL wrap to 0 without error.
REQ-022 After the BURST_LEN-th accepted word SHALL return to IDLE on the next edge with gnt deasserted; zero idle cycles are not required between bursts.
REQ-023 A burst, once granted, SHALL complete regardless of the requester dropping req.
REQ-024 p1_rdata SHALL equal za_data and p1_rvalid SHALL equal za_valid, registered (one cycle latency), independent of current state.
REQ-025 rd_pending SHALL decrement on each za_valid; simultaneous issue and return SHALL leave it unchanged; it SHALL saturate at 255 and never underflow below 0.
REQ-026 p0_gnt and p1_gnt SHALL never be 1 in the same cycle.

Reset
REQ-027 reset=1 SHALL immediately force state IDLE, p0_gnt=p1_gnt=p0_ack=p1_rvalid=0, az_cs=0, az_rd_n=az_wr_n=1, az_addr=0, az_data=0, p1_rdata=0, rd_pending=0, last-served = port 1.
REQ-028 Reset mid-burst SHALL abandon the burst; no partial-burst state survives.
REQ-029 After reset deasserts, first arbitration SHALL occur on the first clk edge.

Configuration
REQ-030 With macro SDRAM_ARB_RX_PRIO_EN defined: on simultaneous requests port 0 SHALL always win (RX path never stalls behind playback).
REQ-031 Without SDRAM_ARB_RX_PRIO_EN: simultaneous requests SHALL be resolved round-robin — the port not served last wins; last-served updates at each grant.

Verification
REQ-032 p0_req, p0_addr=0x000010, BURST_LEN=8, no waitrequest -> 8 writes to 0x10..0x17, 8 p0_ack pulses, p0_gnt high 8 cycles.
REQ-033 p1_req at 0x3FFFFC, za_waitrequest high on 2nd word for 3 cycles -> addresses 0x3FFFFC,FD,FE,FF,0,1,2,3; address held during stall; rd_pending peaks then returns to 0 after 8 za_valid.
REQ-034 p0_req and p1_req held high continuously, macro undefined -> grants alternate P0,P1,P0,P1 burst by burst; macro defined -> P0 only.
REQ-035 reset pulsed on 4th word of a write burst -> az_cs=0, p0_gnt=0 in same cycle; new burst after reset starts at new p0_addr, count 0.
REQ-036 za_valid coincident with read issue at rd_pending=3 -> rd_pending stays 3; p1_rvalid follows za_valid by exactly one cycle with matching data.
